// File: rtl/rx_frame_pkg.sv
// Shared types and line-level constants for the receive frame controller.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_HALF,
    DATA_WAIT,
    PARITY_WAIT,
    STOP_WAIT,
    LOAD
  } rx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter: counts 0..rollover_val_i-1 and wraps, flag high on the last count.
module rx_bit_timer #(
  parameter int TIMER_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [TIMER_W:0] rollover_val_i,
  output logic             rollover_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  assign rollover_o = ({1'b0, count_q} == (rollover_val_i - (TIMER_W+1)'(1)));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = rollover_o ? '0 : count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-side sequencer: start detect, mid-bit shift strobes, stop check, load and status flags.
// Optional even-parity checking is built when RX_PARITY_EN is defined.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 10,
  parameter  int DATA_BITS    = 8,
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
`ifdef RX_PARITY_EN
  output logic parity_error,
`endif
  output logic overrun_error,
  output logic busy
);

  localparam int               BC_W     = $clog2(DATA_BITS + 1);
  localparam logic [TIMER_W:0] FULL_VAL = (TIMER_W+1)'(CLKS_PER_BIT);
  localparam logic [TIMER_W:0] HALF_VAL = (TIMER_W+1)'(CLKS_PER_BIT / 2);

  rx_state_t        state_q;
  logic             line_q;
  logic             armed_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic             data_ready_q;
  logic             framing_q;
  logic             overrun_q;
`ifdef RX_PARITY_EN
  logic             parity_acc_q;
  logic             parity_err_q;
  logic             parity_bad_q;
`endif

  logic             timer_clr;
  logic             rollover;
  logic [TIMER_W:0] rollover_val;
  logic             start_edge;

  // Only a genuine 1->0 transition counts; a line held low through reset must first go idle.
  assign start_edge   = armed_q && (line_q == LINE_IDLE) && (serial_in == START_LEVEL);
  assign timer_clr    = (state_q == IDLE) || (state_q == LOAD);
  assign rollover_val = (state_q == START_HALF) ? HALF_VAL : FULL_VAL;

  rx_bit_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (timer_clr),
    .count_en_i    (!timer_clr),
    .rollover_val_i(rollover_val),
    .rollover_o    (rollover)
  );

  assign shift_enable  = (state_q == DATA_WAIT) && rollover;
  assign load_buffer   = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign data_ready    = data_ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
`ifdef RX_PARITY_EN
  assign parity_error  = parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_q       <= LINE_IDLE;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      data_ready_q <= 1'b0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
      parity_acc_q <= 1'b0;
      parity_err_q <= 1'b0;
      parity_bad_q <= 1'b0;
`endif
    end else begin
      line_q <= serial_in;
      if (serial_in == LINE_IDLE) begin
        armed_q <= 1'b1;
      end

      // Consumer handshake; a simultaneous read keeps data_ready and suppresses overrun.
      if (load_buffer) begin
        data_ready_q <= 1'b1;
        if (data_read) begin
          overrun_q <= 1'b0;
        end else if (data_ready_q) begin
          overrun_q <= 1'b1;
        end
      end else if (data_read) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (start_edge) begin
            state_q   <= START_HALF;
            framing_q <= 1'b0;
`ifdef RX_PARITY_EN
            parity_acc_q <= 1'b0;
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
          end
        end
        START_HALF: begin
          if (rollover) begin
            state_q <= (serial_in == START_LEVEL) ? DATA_WAIT : IDLE;
          end
        end
        DATA_WAIT: begin
          if (rollover) begin
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
`ifdef RX_PARITY_EN
            parity_acc_q <= parity_acc_q ^ serial_in;
`endif
            if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
              state_q <= PARITY_WAIT;
`else
              state_q <= STOP_WAIT;
`endif
            end
          end
        end
`ifdef RX_PARITY_EN
        PARITY_WAIT: begin
          if (rollover) begin
            if (parity_acc_q ^ serial_in) begin
              parity_err_q <= 1'b1;
              parity_bad_q <= 1'b1;
            end
            state_q <= STOP_WAIT;
          end
        end
`endif
        STOP_WAIT: begin
          if (rollover) begin
            if (serial_in == LINE_IDLE) begin
`ifdef RX_PARITY_EN
              state_q <= parity_bad_q ? IDLE : LOAD;
`else
              state_q <= LOAD;
`endif
            end else begin
              framing_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        LOAD: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: drives serial frames, models the attached SR and output buffer,
// and scoreboards loaded bytes, strobe timing and status flags.
module tb_rx_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic data_read = 1'b0;
  logic shift_enable;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;
  logic busy;

  rx_frame_ctrl #(
    .CLKS_PER_BIT(10),
    .DATA_BITS   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .shift_enable (shift_enable),
    .load_buffer  (load_buffer),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int shifts_total = 0;
  int shift_snap = 0;
  int loads_total = 0;
  logic [7:0] sr_q = 8'h00;
  logic [7:0] buf_q = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift_enable) sr_q <= {sr_q[6:0], serial_in};
    if (load_buffer) buf_q <= sr_q;
  end

  // Strobe timing is measured from t0, the edge that first samples the start bit.
  always @(negedge clk) begin
    if (shift_enable) begin
      chk("shift_time", cyc + 1 - t0, 15 + 10 * (shifts_total - shift_snap));
      shifts_total++;
    end
    if (load_buffer) begin
      chk("load_time", cyc + 1 - t0, 96);
      chk("load_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("load_data", sr_q, exp_q.pop_front());
      loads_total++;
    end
  end

  task automatic begin_start();
    serial_in  = 1'b0;
    t0         = cyc + 1;
    shift_snap = shifts_total;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    if (stop) exp_q.push_back(data);
    begin_start();
    tick(10);
    for (int b = 7; b >= 0; b--) begin
      serial_in = data[b];
      tick(10);
    end
    serial_in = stop;
    tick(10);
    serial_in = 1'b1;
    tick(1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       read_first;
    int         exp_loads;
    logic       exp_ready;
    logic       exp_ferr;
    logic       exp_ovr;
    logic [7:0] exp_buf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int ls;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 8'h22};

    // Reset with the line held low; releasing reset must not look like a start bit.
    rst = 1'b1;
    serial_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_ovr", overrun_error, 0);
    chk("rst_shift", shifts_total, 0);
    chk("rst_load", loads_total, 0);
    $display("reset: busy=%0b ready=%0b ferr=%0b ovr=%0b", busy, data_ready, framing_error, overrun_error);

    // Two-cycle low glitch on an idle line is rejected at the half-bit sample.
    serial_in = 1'b1;
    tick(2);
    begin_start();
    tick(2);
    serial_in = 1'b1;
    chk("glitch_busy_early", busy, 1);
    tick(3);
    chk("glitch_busy_t4", busy, 1);
    tick(1);
    chk("glitch_idle_t5", busy, 0);
    tick(5);
    chk("glitch_shifts", shifts_total - shift_snap, 0);
    chk("glitch_ferr", framing_error, 0);
    chk("glitch_ready", data_ready, 0);
    $display("glitch: busy=%0b shifts=%0d", busy, shifts_total - shift_snap);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].read_first) begin
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
      end
      ls = loads_total;
      send_frame(vecs[i].data, vecs[i].stop);
      chk("frame_shifts", shifts_total - shift_snap, 8);
      chk("frame_loads", loads_total - ls, vecs[i].exp_loads);
      chk("frame_ready", data_ready, int'(vecs[i].exp_ready));
      chk("frame_ferr", framing_error, int'(vecs[i].exp_ferr));
      chk("frame_ovr", overrun_error, int'(vecs[i].exp_ovr));
      chk("frame_buf", buf_q, vecs[i].exp_buf);
      chk("frame_busy", busy, 0);
      $display("frame %0d: data=0x%02h stop=%0b loads=%0d ready=%0b ferr=%0b ovr=%0b buf=0x%02h",
               i, vecs[i].data, vecs[i].stop, loads_total - ls, data_ready, framing_error,
               overrun_error, buf_q);
    end

    // A single read acknowledge clears both sticky handshake flags.
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    chk("read_ready", data_ready, 0);
    chk("read_ovr", overrun_error, 0);
    $display("data_read: ready=%0b ovr=%0b", data_ready, overrun_error);

    // Reset lands at t0+40 in the middle of a frame; nothing may be loaded for it.
    ls = loads_total;
    begin_start();
    tick(10);
    serial_in = 1'b0;
    tick(10);
    serial_in = 1'b1;
    tick(10);
    serial_in = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    serial_in = 1'b1;
    tick(5);
    chk("abort_shifts", shifts_total - shift_snap, 3);
    chk("abort_loads", loads_total - ls, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", data_ready, 0);
    $display("abort: shifts=%0d loads=%0d busy=%0b", shifts_total - shift_snap, loads_total - ls, busy);

    ls = loads_total;
    send_frame(8'hFF, 1'b1);
    chk("ff_shifts", shifts_total - shift_snap, 8);
    chk("ff_loads", loads_total - ls, 1);
    chk("ff_buf", buf_q, 8'hFF);
    chk("ff_ready", data_ready, 1);
    chk("ff_ovr", overrun_error, 0);
    $display("frame ff: loads=%0d ready=%0b buf=0x%02h", loads_total - ls, data_ready, buf_q);

    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
